// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU boot path: loader states and word/memory sizing.
package cpu_pkg;

  localparam int WORD_W       = 32;
  localparam int IM_DEPTH_DEF = 64;

  typedef enum logic [1:0] {
    LOAD,
    HOLD,
    RUN,
    ERROR
  } load_state_e;

endpackage

// File: rtl/program_loader.sv
// Streams a program into instruction memory over valid/ready, then releases the
// CPU from reset after a short hold; flags overflow when the program cannot fit.
module program_loader
  import cpu_pkg::*;
#(
  parameter int IM_DEPTH = IM_DEPTH_DEF,
  parameter int ADDR_W   = 6,
  parameter int RST_HOLD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int HOLD_W = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD);
  localparam logic [ADDR_W:0]   LAST_IDX  = (ADDR_W + 1)'(IM_DEPTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  load_state_e       state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              accept;

  // Ready is gated by the reset pin so nothing is offered while held in reset.
  assign in_ready = rst & (state_q == LOAD);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      count_q <= '0;
      hold_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hold_d  = hold_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          wdata_d = in_data;
          count_d = count_q + 1'b1;
          if (in_last) begin
            state_d = HOLD;
            hold_d  = '0;
          end else if (count_q == LAST_IDX) begin
            // The final in-range word is still written; anything after it is refused.
            state_d = ERROR;
          end
        end
      end

      HOLD: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_LAST) begin
          state_d = RUN;
        end
      end

      RUN, ERROR: begin
        if (reload) begin
          state_d = LOAD;
          count_d = '0;
        end
      end

      default: begin
        state_d = LOAD;
        count_d = '0;
      end
    endcase
  end

  assign im_we      = we_q;
  assign im_addr    = addr_q;
  assign im_wdata   = wdata_q;
  assign word_count = count_q;
  assign done       = (state_q == RUN);
  assign cpu_rst    = (state_q != RUN);
  assign error      = (state_q == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader, checked every cycle against a transaction-level model.
module tb_program_loader;

  localparam int IM_DEPTH = 64;
  localparam int ADDR_W   = 6;
  localparam int RST_HOLD = 2;

  localparam int P_LOAD = 0;
  localparam int P_HOLD = 1;
  localparam int P_RUN  = 2;
  localparam int P_ERR  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_data = '0;
  logic              in_last = 1'b0;
  logic              reload = 1'b0;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  program_loader #(.IM_DEPTH(IM_DEPTH), .ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .reload(reload),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          m_phase;
  int          m_count;
  int          m_hold_left;
  bit          m_wr;
  int          m_wr_addr;
  logic [31:0] m_wr_data;
  logic [31:0] exp_mem [IM_DEPTH];
  logic [31:0] dut_mem [IM_DEPTH];
  logic [31:0] prog [80];
  int          cyc = 0;
  int          last_we_cyc = -1;
  int          first_done_cyc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic budget_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout expected completion (cycle %0d)", name, cyc);
  endtask

  task automatic model_reset();
    m_phase     = P_LOAD;
    m_count     = 0;
    m_hold_left = 0;
    m_wr        = 0;
  endtask

  // What the next rising edge must do, stated as transactions rather than signals.
  task automatic model_step(input bit v, input logic [31:0] d, input bit l, input bit r);
    m_wr = 0;
    case (m_phase)
      P_LOAD: if (v) begin
        m_wr             = 1;
        m_wr_addr        = m_count;
        m_wr_data        = d;
        exp_mem[m_count] = d;
        m_count++;
        if (l) begin
          m_phase     = P_HOLD;
          m_hold_left = RST_HOLD;
        end else if (m_count == IM_DEPTH) begin
          m_phase = P_ERR;
        end
      end
      P_HOLD: begin
        m_hold_left--;
        if (m_hold_left == 0) m_phase = P_RUN;
      end
      default: if (r) begin
        m_phase = P_LOAD;
        m_count = 0;
      end
    endcase
  endtask

  task automatic check_cycle();
    chk("in_ready",   in_ready,   m_phase == P_LOAD);
    chk("cpu_rst",    cpu_rst,    m_phase != P_RUN);
    chk("done",       done,       m_phase == P_RUN);
    chk("error",      error,      m_phase == P_ERR);
    chk("word_count", word_count, m_count);
    chk("im_we",      im_we,      m_wr);
    if (m_wr) begin
      chk("im_addr",  im_addr,  m_wr_addr);
      chk("im_wdata", im_wdata, m_wr_data);
    end
    if (im_we === 1'b1) begin
      dut_mem[im_addr] = im_wdata;
      last_we_cyc = cyc;
    end
    if (done === 1'b1 && first_done_cyc < 0) first_done_cyc = cyc;
  endtask

  // Drive one cycle of inputs just after a falling edge, then check on the next one.
  task automatic tick(input bit v, input logic [31:0] d, input bit l, input bit r);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    reload   = r;
    model_step(v && (m_phase == P_LOAD), d, l, r);
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  task automatic fill_prog(input int n);
    for (int i = 0; i < n; i++) prog[i] = $urandom;
  endtask

  // gap_mode: -1 alternates valid each cycle, otherwise percent chance of valid.
  task automatic send_words(input int n, input int last_at, input int gap_mode, input bit rnd_reload);
    int  i = 0;
    int  budget = 0;
    bit  v;
    bit  acc;
    while (i < n && m_phase == P_LOAD && budget < 2000) begin
      if (gap_mode < 0) v = (budget % 2) == 0;
      else              v = $urandom_range(99) < gap_mode;
      acc = v && (m_phase == P_LOAD);
      tick(v, prog[i], (i + 1) == last_at, rnd_reload && ($urandom_range(5) == 0));
      if (acc) i++;
      budget++;
    end
    if (budget >= 2000) budget_fail("load_budget");
  endtask

  task automatic wait_settled();
    int budget = 0;
    while (m_phase != P_RUN && m_phase != P_ERR && budget < 100) begin
      tick($urandom_range(1), $urandom, 1'b0, $urandom_range(1));
      budget++;
    end
    if (budget >= 100) budget_fail("settle_budget");
    tick(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reload();
    tick($urandom_range(1), $urandom, 1'b0, 1'b1);
  endtask

  task automatic check_image(input string name);
    int bad = 0;
    for (int a = 0; a < IM_DEPTH; a++) if (dut_mem[a] !== exp_mem[a]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"},   in_ready,   0);
    chk({tag, "_im_we"},      im_we,      0);
    chk({tag, "_im_addr"},    im_addr,    0);
    chk({tag, "_im_wdata"},   im_wdata,   0);
    chk({tag, "_cpu_rst"},    cpu_rst,    1);
    chk({tag, "_done"},       done,       0);
    chk({tag, "_error"},      error,      0);
    chk({tag, "_word_count"}, word_count, 0);
  endtask

  task automatic apply_reset();
    #2 rst = 1'b0;
    #1 check_reset_values("rst_mid");
    model_reset();
    @(negedge clk);
    cyc++;
    check_reset_values("rst_hold");
    rst = 1'b1;
    #1 check_cycle();
  endtask

  initial begin
    int n;
    int pct;
    for (int a = 0; a < IM_DEPTH; a++) begin
      exp_mem[a] = '0;
      dut_mem[a] = '0;
    end
    model_reset();

    #12 check_reset_values("por");
    @(negedge clk);
    rst = 1'b1;
    #1 check_cycle();

    fill_prog(25);
    first_done_cyc = -1;
    send_words(25, 25, 100, 1'b0);
    wait_settled();
    chk("s1_word_count", word_count, 25);
    chk("s1_done", done, 1);
    chk("s1_release_delay", first_done_cyc - last_we_cyc, 2);
    chk("s1_last_word", dut_mem[24], prog[24]);
    check_image("s1_image");

    do_reload();
    send_words(25, 25, -1, 1'b0);
    wait_settled();
    chk("s2_word_count", word_count, 25);
    check_image("s2_image");

    do_reload();
    fill_prog(65);
    send_words(65, 0, 100, 1'b0);
    for (int k = 0; k < 4; k++) tick(1'b1, prog[64], 1'b0, 1'b0);
    chk("s3_error", error, 1);
    chk("s3_in_ready", in_ready, 0);
    chk("s3_cpu_rst", cpu_rst, 1);
    chk("s3_word_count", word_count, 64);
    chk("s3_top_word", dut_mem[63], prog[63]);
    check_image("s3_image");

    do_reload();
    fill_prog(64);
    send_words(64, 64, 70, 1'b0);
    wait_settled();
    chk("s4_word_count", word_count, 64);
    chk("s4_done", done, 1);
    chk("s4_error", error, 0);
    check_image("s4_image");

    do_reload();
    prog[0] = 32'h2010_0200;
    send_words(1, 1, 100, 1'b0);
    wait_settled();
    chk("s5_word0", dut_mem[0], 32'h2010_0200);
    chk("s5_word_count", word_count, 1);
    check_image("s5_image");

    do_reload();
    fill_prog(25);
    send_words(10, 0, 100, 1'b0);
    apply_reset();
    send_words(25, 25, 80, 1'b1);
    wait_settled();
    chk("s6_word_count", word_count, 25);
    chk("s6_done", done, 1);
    check_image("s6_image");

    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 3; k++) tick($urandom_range(1), $urandom, $urandom_range(1), 1'b0);
      do_reload();
      n   = $urandom_range(70, 1);
      pct = $urandom_range(100, 30);
      fill_prog(n);
      send_words(n, (n > IM_DEPTH) ? 0 : n, pct, 1'b1);
      wait_settled();
      check_image("rand_image");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Streams a program into the single-cycle CPU's instruction memory over a valid/ready word interface, then releases the CPU from reset.
- Sits directly upstream of CPU_SingleCycle. Replaces the direct testbench writes to instruction memory with a synthesizable boot path.
- Holds the CPU in reset while loading and for a programmable number of cycles afterwards. Flags overflow if the program does not fit.

Parameters:
IM_DEPTH, 64, instruction memory depth in words (power of two, >=2)
ADDR_W, 6, word-address width (= log2(IM_DEPTH))
RST_HOLD, 2, cycles cpu_rst stays high after the final write (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous, active-low
in_valid  input  1  in_data/in_last valid
in_ready  output  1  loader accepts a word this cycle
in_data  input  32  instruction word
in_last  input  1  marks final word of program
reload  input  1  one-cycle request to restart loading (honoured in RUN/ERROR only)
im_we  output  1  instruction memory write enable
im_addr  output  ADDR_W  instruction memory word address
im_wdata  output  32  instruction memory write data
cpu_rst  output  1  active-high reset to CPU_SingleCycle
done  output  1  program loaded, CPU running
error  output  1  overflow: more than IM_DEPTH words without in_last
word_count  output  ADDR_W+1  words written in current load

Behaviour:
- Reset values (rst=0, asynchronous): state=LOAD, in_ready=0 during reset (1 after), im_we=0, im_addr=0, im_wdata=0, cpu_rst=1, done=0, error=0, word_count=0, hold counter=0.
- Handshake: word accepted iff in_valid & in_ready on a rising edge. in_ready depends only on state (high only in LOAD), never on in_valid.
- Write latency 1: accepted word appears next cycle as im_we=1, im_addr=word_count(before increment), im_wdata=in_data. im_we is high exactly one cycle per accepted word. word_count increments on the same edge.
- States:
  - LOAD: in_ready=1, cpu_rst=1.
    - Accept with in_last=1 -> HOLD, hold counter cleared.
    - Accept with in_last=0 and word_count==IM_DEPTH-1 -> ERROR; the last in-range word is still written.
    - Otherwise stay in LOAD.
  - HOLD: in_ready=0, cpu_rst=1. Counter increments each cycle; after RST_HOLD cycles in HOLD -> RUN. The final word's im_we pulse occurs in the first HOLD cycle.
  - RUN: cpu_rst=0, done=1, in_ready=0. reload=1 -> LOAD, word_count=0, done=0, cpu_rst=1 on the next cycle.
  - ERROR: cpu_rst=1, error=1, in_ready=0, done=0. reload=1 -> LOAD with error cleared and word_count=0.
- reload is ignored in LOAD and HOLD.
- in_last on word IM_DEPTH (exactly full) is legal: -> HOLD, word_count=IM_DEPTH, no error.
- Addresses never wrap; writes beyond IM_DEPTH-1 never occur.
- Reset mid-load: all state discarded immediately. Memory contents are not cleared; a new load overwrites from address 0.
- Words not rewritten by a shorter program keep stale contents (documented, not an error).
- done and error are mutually exclusive. cpu_rst is the complement of done.

Decomposition:
- Shared package cpu_pkg: state enum {LOAD, HOLD, RUN, ERROR}, WORD_W=32 constant, IM_DEPTH default.
- No sub-module. Single FSM plus write register stage. The hold counter is inline.

Test Plan:
- Load the 25-word bubble-sort program, in_valid continuous, in_last on word 25 -> im_we pulses at addresses 0..24 with matching data; cpu_rst falls RST_HOLD=2 cycles after the last write cycle; done=1, word_count=25; CPU then reaches PC=100 with the array sorted.
- Same program with in_valid deasserted every other cycle -> identical memory image, im_we only on accepted words, word_count=25.
- IM_DEPTH=64, 65 words with in_last never set -> addresses 0..63 written, error=1 after word 64, in_ready=0, cpu_rst stays 1, word 65 never accepted.
- 64 words with in_last on word 64 -> no error, done=1, word_count=64.
- In RUN pulse reload, then load 1 word (in_last=1, data 0x20100200) -> cpu_rst=1 next cycle, single write to address 0, done after RST_HOLD.
- Assert rst low after 10 of 25 words accepted, release, reload full program -> outputs at reset values during reset, writes restart at address 0, done=1 with word_count=25.
